// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO slice: the per-cycle stack operation decoded
// from the qualified push/pop requests.
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_SWAP
  } lifo_op_e;

  function automatic lifo_op_e decode_op(input logic wr_ok, input logic rd_ok);
    if (wr_ok && rd_ok) return OP_SWAP;
    if (wr_ok)          return OP_PUSH;
    if (rd_ok)          return OP_POP;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/lifo_ram.sv
// Simple dual-port stack storage with a registered read port that holds its
// value unless a read is enabled; intended to map onto block RAM.
module lifo_ram #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  // A same-address write and read in one cycle returns the old word, which is
  // what the top relies on when swapping the top of stack.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (srst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lifo.sv
// Single-clock LIFO: occupancy counter, request qualification and flag decode
// around a registered-output stack RAM.
module lifo
  import lifo_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 8,
  parameter int ALMOST_FULL  = 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              almost_empty_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o
);

  localparam int DEPTH  = 2**AWIDTH;
  localparam int AF_INT = DEPTH - ALMOST_FULL;

  localparam logic [AWIDTH:0]   DEPTH_LVL = DEPTH[AWIDTH:0];
  localparam logic [AWIDTH:0]   AF_LVL    = AF_INT[AWIDTH:0];
  localparam logic [AWIDTH:0]   AE_LVL    = ALMOST_EMPTY[AWIDTH:0];
  localparam logic [AWIDTH:0]   ONE       = 1;
  localparam logic [AWIDTH-1:0] ONE_A     = 1;

  logic [AWIDTH:0]   usedw;
  logic [AWIDTH-1:0] push_addr;
  logic [AWIDTH-1:0] top_addr;
  logic              wr_ok;
  logic              rd_ok;
  lifo_op_e          op;

  assign empty_o        = (usedw == '0);
  assign full_o         = (usedw == DEPTH_LVL);
  assign almost_empty_o = (usedw <= AE_LVL);
  assign almost_full_o  = (usedw >= AF_LVL);
  assign usedw_o        = usedw;

  // When full the low bits wrap to 0, so top_addr still lands on DEPTH-1.
  assign push_addr = usedw[AWIDTH-1:0];
  assign top_addr  = push_addr - ONE_A;

  // A push while full is still allowed when paired with a pop (top replace).
  assign rd_ok = rdreq_i && !empty_o;
  assign wr_ok = wrreq_i && (!full_o || rd_ok);
  assign op    = decode_op(wr_ok, rd_ok);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      usedw <= '0;
    end else begin
      case (op)
        OP_PUSH: usedw <= usedw + ONE;
        OP_POP:  usedw <= usedw - ONE;
        default: usedw <= usedw;
      endcase
    end
  end

  lifo_ram #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_ram (
    .clk     (clk_i),
    .srst    (srst_i),
    .wr_en   (wr_ok && !srst_i),
    .wr_addr ((op == OP_SWAP) ? top_addr : push_addr),
    .wr_data (data_i),
    .rd_en   (rd_ok),
    .rd_addr (top_addr),
    .rd_data (q_o)
  );

endmodule

// File: tb/tb_lifo.sv
// Directed self-checking bench for lifo at default parameters: fill/drain
// ordering, flag thresholds, empty pops, top replacement and reset.
module tb_lifo;

  logic        clk = 1'b0;
  logic        srst_i = 1'b0;
  logic        wrreq_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        rdreq_i = 1'b0;
  logic [15:0] q_o;
  logic        almost_empty_o;
  logic        empty_o;
  logic        almost_full_o;
  logic        full_o;
  logic [8:0]  usedw_o;

  int assert_count = 0;
  int fail_count = 0;
  logic [15:0] stored [256];
  logic [15:0] last_q;

  lifo dut (
    .clk_i          (clk),
    .srst_i         (srst_i),
    .wrreq_i        (wrreq_i),
    .data_i         (data_i),
    .rdreq_i        (rdreq_i),
    .q_o            (q_o),
    .almost_empty_o (almost_empty_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .full_o         (full_o),
    .usedw_o        (usedw_o)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; inputs change on the falling edge, results are
  // observable 1ns after the rising edge and inputs then return to idle.
  task automatic applyStimulus(input logic rst, input logic wr,
                               input logic [15:0] d, input logic rd);
    @(negedge clk);
    srst_i  = rst;
    wrreq_i = wr;
    data_i  = d;
    rdreq_i = rd;
    @(posedge clk);
    #1;
    srst_i  = 1'b0;
    wrreq_i = 1'b0;
    rdreq_i = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset then idle
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h5555, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    checkOutput("rst_usedw", usedw_o, 0);
    checkOutput("rst_empty", empty_o, 1);
    checkOutput("rst_aempty", almost_empty_o, 1);
    checkOutput("rst_full", full_o, 0);
    checkOutput("rst_afull", almost_full_o, 0);
    checkOutput("rst_q", q_o, 0);

    // Fill with random words, checking flag thresholds on the way
    for (int k = 1; k <= 256; k++) begin
      stored[k-1] = 16'($urandom_range(0, 65535));
      applyStimulus(1'b0, 1'b1, stored[k-1], 1'b0);
      checkOutput("fill_usedw", usedw_o, k);
      if (k == 2)   checkOutput("ae_at2", almost_empty_o, 1);
      if (k == 3)   checkOutput("ae_at3", almost_empty_o, 0);
      if (k == 253) checkOutput("af_at253", almost_full_o, 0);
      if (k == 254) checkOutput("af_at254", almost_full_o, 1);
      if (k == 255) checkOutput("full_at255", full_o, 0);
      if (k == 256) checkOutput("full_at256", full_o, 1);
    end
    checkOutput("fill_q_hold", q_o, 0);

    // Push while full is dropped
    applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b0);
    checkOutput("ovf_usedw", usedw_o, 256);
    checkOutput("ovf_full", full_o, 1);
    checkOutput("ovf_afull", almost_full_o, 1);

    // Replace top while full
    applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b1);
    checkOutput("swapfull_q", q_o, {16'h0, stored[255]});
    checkOutput("swapfull_usedw", usedw_o, 256);
    stored[255] = 16'hBEEF;

    // Drain in reverse order, one cycle latency per pop
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      checkOutput("drain_q", q_o, {16'h0, stored[255-i]});
      checkOutput("drain_usedw", usedw_o, 255 - i);
    end
    checkOutput("drain_empty", empty_o, 1);

    // Pops on empty are ignored
    last_q = q_o;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    checkOutput("udf_usedw", usedw_o, 0);
    checkOutput("udf_q", q_o, {16'h0, stored[0]});
    checkOutput("udf_empty", empty_o, 1);

    // Push+pop on empty behaves as push only
    applyStimulus(1'b0, 1'b1, 16'h7777, 1'b1);
    checkOutput("swapempty_usedw", usedw_o, 1);
    checkOutput("swapempty_q", q_o, {16'h0, last_q});
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    checkOutput("swapempty_pop", q_o, 16'h7777);

    // Top replacement with A, B then C+pop
    applyStimulus(1'b0, 1'b1, 16'h1111, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h2222, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h3333, 1'b1);
    checkOutput("swap_q", q_o, 16'h2222);
    checkOutput("swap_usedw", usedw_o, 2);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    checkOutput("swap_pop1", q_o, 16'h3333);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    checkOutput("swap_pop2", q_o, 16'h1111);
    checkOutput("swap_usedw_end", usedw_o, 0);

    // Reset with data stored and a pop pending
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 16'(16'h0100 + i), 1'b0);
    checkOutput("pre_rst_usedw", usedw_o, 10);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1);
    checkOutput("midrst_usedw", usedw_o, 0);
    checkOutput("midrst_empty", empty_o, 1);
    checkOutput("midrst_q", q_o, 0);
    applyStimulus(1'b0, 1'b1, 16'hABCD, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    checkOutput("post_rst_q", q_o, 16'hABCD);
    checkOutput("post_rst_usedw", usedw_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
